axis_weight_preload: RTL



---
 rtl/axis_weight_preload_pkg.sv | 39 +++
 rtl/weight_fwft_fifo.sv | 77 +++++++
 rtl/axis_weight_preload.sv | 120 ++++++++++++
 3 files changed

// File: rtl/axis_weight_preload_pkg.sv
// Shared helpers and derived widths for the weight preload stage.
package axis_weight_preload_pkg;

    localparam int unsigned MAC_NUM_DEF     = 256;
    localparam int unsigned AXIS_DW_DEF     = 64;
    localparam int unsigned FIFO_DEPTH_DEF  = 4;

    // Number of bits needed to hold 'value' (0 -> 0, 3 -> 2, 4 -> 3).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v != 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // Each MAC takes a 5-bit weight.
    function automatic int unsigned vec_width(input int unsigned mac_num);
        return 5 * mac_num;
    endfunction

    function automatic int unsigned beats_per_vec(input int unsigned vec_w,
                                                  input int unsigned data_w);
        return vec_w / data_w;
    endfunction

    // The packer only supports vectors that are a whole number of beats.
    function automatic bit width_ok(input int unsigned vec_w,
                                    input int unsigned data_w);
        return (data_w != 0) && ((vec_w % data_w) == 0) && (vec_w >= data_w);
    endfunction

endpackage

// File: rtl/weight_fwft_fifo.sv
// First-word-fall-through vector FIFO: head entry is visible on data_o
// whenever cnt_o != 0. Pops on empty and pushes on full (without a
// simultaneous pop) are dropped.
module weight_fwft_fifo #(
    parameter int unsigned WIDTH = 1280,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_eff;
    logic             push_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_eff  = pop_i && (cnt_q != '0);
    assign push_eff = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_eff);

    // Pointer and occupancy next-state; clear overrides push/pop.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_eff) tail_d = ptr_inc(tail_q);
            if (pop_eff)  head_d = ptr_inc(head_q);
            if (push_eff && !pop_eff)      cnt_d = cnt_q + CNT_W'(1);
            else if (!push_eff && pop_eff) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; reset to zero so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (!clr_i && push_eff) begin
            mem_q[tail_q] <= data_i;
        end
    end

    assign data_o = mem_q[head_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/axis_weight_preload.sv
// AXI4-Stream weight packer: assembles beats into full weight vectors
// (beat 0 in the LSBs) and queues them in a FWFT FIFO for the BRAM writer.
module axis_weight_preload
    import axis_weight_preload_pkg::*;
#(
    parameter int unsigned MAC_NUM                 = MAC_NUM_DEF,
    parameter int unsigned AXIS_DATA_WIDTH         = AXIS_DW_DEF,
    parameter int unsigned AXIS_PRELOAD_FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned VEC_W   = vec_width(MAC_NUM),
    localparam int unsigned bit_num = clogb2(AXIS_PRELOAD_FIFO_DEPTH - 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    input  logic                       preload_clear,
    input  logic                       axis_fifo_read,
    output logic [VEC_W-1:0]           weight_from_preload,
    output logic [bit_num:0]           axis_fifo_cnt,
    output logic                       wait_weight_preload,
    output logic                       pack_err
);

    localparam int unsigned W      = AXIS_DATA_WIDTH;
    localparam int unsigned DEPTH  = AXIS_PRELOAD_FIFO_DEPTH;
    localparam int unsigned BEATS  = beats_per_vec(VEC_W, W);
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = bit_num + 1;
    localparam int unsigned PACK_W = (BEATS > 1) ? (BEATS - 1) * W : W;

    // Refuse to elaborate unsupported geometries.
    if (!width_ok(VEC_W, W)) begin : g_bad_width
        $error("axis_weight_preload: vector width must be a multiple of AXIS_DATA_WIDTH");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("axis_weight_preload: AXIS_PRELOAD_FIFO_DEPTH must be at least 2");
    end

    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic [PACK_W-1:0] pack_q, pack_d;
    logic              pack_err_q, pack_err_d;
    logic [VEC_W-1:0]  push_vec_c;
    logic              last_slot;
    logic              fifo_full;
    logic              beat_acc;
    logic              push;

    assign last_slot = (beat_idx_q == IDX_W'(BEATS - 1));
    assign fifo_full = (axis_fifo_cnt == CNT_W'(DEPTH));

    // Only the closing beat stalls on a full FIFO; reads never feed tready.
    assign s_axis_tready = !(last_slot && fifo_full) && !preload_clear;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign push          = beat_acc && (last_slot || s_axis_tlast);

    // Vector to push: stored beats below the current slot, the live beat
    // in the current slot, zeros above (covers early tlast).
    always_comb begin
        push_vec_c = '0;
        for (int unsigned j = 0; j < BEATS; j++) begin
            if (IDX_W'(j) == beat_idx_q) begin
                push_vec_c[j*W +: W] = s_axis_tdata;
            end else if ((j < BEATS - 1) && (IDX_W'(j) < beat_idx_q)) begin
                push_vec_c[j*W +: W] = pack_q[j*W +: W];
            end
        end
    end

    // Packer next-state: beat index, pack register, sticky framing error.
    always_comb begin
        beat_idx_d = beat_idx_q;
        pack_d     = pack_q;
        pack_err_d = pack_err_q;
        if (preload_clear) begin
            beat_idx_d = '0;
            pack_err_d = 1'b0;
        end else if (beat_acc) begin
            for (int unsigned j = 0; j < BEATS - 1; j++) begin
                if (IDX_W'(j) == beat_idx_q) pack_d[j*W +: W] = s_axis_tdata;
            end
            if (last_slot || s_axis_tlast) beat_idx_d = '0;
            else                           beat_idx_d = beat_idx_q + IDX_W'(1);
            if (s_axis_tlast && !last_slot) pack_err_d = 1'b1;
        end
    end

    // Packer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx_q <= '0;
            pack_q     <= '0;
            pack_err_q <= 1'b0;
        end else begin
            beat_idx_q <= beat_idx_d;
            pack_q     <= pack_d;
            pack_err_q <= pack_err_d;
        end
    end

    weight_fwft_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (preload_clear),
        .push_i (push),
        .data_i (push_vec_c),
        .pop_i  (axis_fifo_read),
        .data_o (weight_from_preload),
        .cnt_o  (axis_fifo_cnt)
    );

    assign wait_weight_preload = (axis_fifo_cnt != '0);
    assign pack_err            = pack_err_q;

endmodule
